conv_window_feeder: RTL

//  Upstream stage of the convolution kernel engine. Accepts a raster-order 8-bit pixel stream,

---
 rtl/conv_window_feeder_if.sv | 25 ++
 rtl/conv_window_feeder.sv | 98 +++++++++
 2 files changed

// File: rtl/conv_window_feeder_if.sv
// conv_window_feeder_if: pixel stream, window and kernel-engine handshake bundle
//   master: stream source / kernel engine side (drives frame_start, in_pixel, in_valid, kern_done)
//   slave : feeder side (drives in_ready, window, kern_start, frame_done)
interface conv_window_feeder_if #(
    parameter int MAX_KERNEL = 3
);
    logic                                       frame_start;
    logic [7:0]                                 in_pixel;
    logic                                       in_valid;
    logic                                       in_ready;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] window;
    logic                                       kern_start;
    logic                                       kern_done;
    logic                                       frame_done;

    modport master (
        output frame_start, in_pixel, in_valid, kern_done,
        input  in_ready, window, kern_start, frame_done
    );

    modport slave (
        input  frame_start, in_pixel, in_valid, kern_done,
        output in_ready, window, kern_start, frame_done
    );
endinterface

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: raster pixel stream -> line buffers + KxK sliding window, one kernel launch per full window
//   clk, n_rst (async, active-low)
//   bus.frame_start/in_pixel/in_valid/kern_done in; bus.in_ready/window/kern_start/frame_done out
module conv_window_feeder #(
    parameter int MAX_KERNEL = 3,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64
) (
    input logic                  clk,
    input logic                  n_rst,
    conv_window_feeder_if.slave  bus
);
    localparam int K  = MAX_KERNEL;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [2:0] {IDLE, FILL, LAUNCH, WAIT, FDONE} state_t;

    state_t                    state, state_nx;
    logic [CW-1:0]             col;
    logic [RW-1:0]             row;
    logic [7:0]                lb [K-1][IMG_W];
    logic [K-1:0][K-1:0][7:0]  win;
    logic [K-1:0][7:0]         column;
    logic                      accept, complete, col_last, row_last, last_win;

    // frame_start blocks acceptance so an aborting restart never consumes a pixel
    assign bus.in_ready   = state == FILL && !bus.frame_start;
    assign bus.kern_start = state == LAUNCH && !bus.frame_start;
    assign bus.frame_done = state == FDONE && !bus.frame_start;
    assign bus.window     = win;

    assign accept   = bus.in_valid && bus.in_ready;
    assign col_last = col == CW'(IMG_W - 1);
    assign row_last = row == RW'(IMG_H - 1);
    assign complete = accept && row >= RW'(K - 1) && col >= CW'(K - 1);

    // column entering the window: oldest line on top, live pixel at the bottom
    always_comb begin
        column = '0;
        for (int r = 0; r < K - 1; r++)
            column[r] = lb[K-2-r][col];
        column[K-1] = bus.in_pixel;
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = state;
        if (bus.frame_start)
            state_nx = FILL;
        else
            case (state)
                FILL:    state_nx = complete ? LAUNCH : FILL;
                LAUNCH:  state_nx = WAIT;
                WAIT:    state_nx = bus.kern_done ? (last_win ? FDONE : FILL) : WAIT;
                FDONE:   state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            col      <= '0;
            row      <= '0;
            last_win <= 1'b0;
        end else if (bus.frame_start) begin
            col      <= '0;
            row      <= '0;
            last_win <= 1'b0;
        end else if (accept) begin
            col <= col_last ? '0 : col + 1'b1;
            row <= col_last ? (row_last ? '0 : row + 1'b1) : row;
            if (complete)
                last_win <= row_last && col_last;
        end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            win <= '0;
            for (int k = 0; k < K - 1; k++)
                for (int x = 0; x < IMG_W; x++)
                    lb[k][x] <= '0;
        end else if (accept) begin
            for (int k = K - 2; k > 0; k--)
                lb[k][col] <= lb[k-1][col];
            lb[0][col] <= bus.in_pixel;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++)
                    win[r][c] <= win[r][c+1];
                win[r][K-1] <= column[r];
            end
        end
endmodule
